ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/mips_pkg.sv | 37 +++
 rtl/ex_mdu.sv | 133 +++++++++++++
 rtl/ex_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the execute stage.
//   * funct codes (instruction bits [5:0]) decoded by ex_stage
//   * ex_state_t: multiply/divide unit state (IDLE, BUSY)
//   * mdu_op_t:   multiply or divide selector for ex_mdu
//   * abs32:      conditional two's-complement magnitude
package mips_pkg;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic {IDLE, BUSY} ex_state_t;

    typedef enum logic {MDU_MUL, MDU_DIV} mdu_op_t;

    // Magnitude of v when it is treated as signed (en=1), else v unchanged.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_mdu.sv
// ex_mdu -- iterative multiply/divide unit.
// A 32-step shift-add multiplier or restoring divider working on operand
// magnitudes; signs are applied on the final step when HI/LO are written.
// Ports:
//   clk_EX, rst_EX   clock, asynchronous active-high reset
//   start            begin an operation (only honoured in IDLE)
//   is_signed        treat op_a/op_b as two's complement
//   op               MDU_MUL or MDU_DIV
//   op_a, op_b       multiplicands, or dividend/divisor
//   busy             high while an operation is in progress
//   hi, lo           most recently completed HI/LO
module ex_mdu
    import mips_pkg::*;
(
    input  logic        clk_EX,
    input  logic        rst_EX,
    input  logic        start,
    input  logic        is_signed,
    input  mdu_op_t     op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    ex_state_t   state, state_nx;
    logic [4:0]  cnt;
    mdu_op_t     op_q;
    logic        neg_main;     // product / quotient must be negated
    logic        neg_rem;      // remainder must be negated
    logic        div0;
    logic [31:0] dividend_q;
    logic [31:0] b_mag;
    logic [31:0] acc_hi;       // product high half, or partial remainder
    logic [31:0] acc_lo;       // multiplier bits, or dividend bits -> quotient

    logic [32:0] mul_sum, div_shift, div_diff;
    logic        div_ge;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod_fix;
    logic [31:0] fin_hi, fin_lo;

    // One iteration of either algorithm.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : 33'd0);
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign div_ge    = ~div_diff[32];

    always_comb begin
        if (op_q == MDU_MUL) begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo[31:1]};
        end else begin
            step_hi = div_ge ? div_diff[31:0] : div_shift[31:0];
            step_lo = {acc_lo[30:0], div_ge};
        end
    end

    // Sign fix-up and divide-by-zero override applied to the last step.
    assign prod_fix = neg_main ? (~{step_hi, step_lo} + 64'd1) : {step_hi, step_lo};

    always_comb begin
        fin_hi = prod_fix[63:32];
        fin_lo = prod_fix[31:0];
        if (op_q == MDU_DIV) begin
            if (div0) begin
                fin_hi = dividend_q;
                fin_lo = 32'hFFFF_FFFF;
            end else begin
                fin_hi = neg_rem  ? (~step_hi + 32'd1) : step_hi;
                fin_lo = neg_main ? (~step_lo + 32'd1) : step_lo;
            end
        end
    end

    // NOTE: the state register is a separate always_ff; the next-state logic
    // is purely combinational with its default assigned first so no latch forms.
    always_ff @(posedge clk_EX or posedge rst_EX) begin
        if (rst_EX) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = BUSY;
            BUSY:    if (cnt == 5'd31) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

    // NOTE: every register here, including HI/LO, is cleared by reset so an
    // operation aborted by reset leaves HI/LO at zero.
    always_ff @(posedge clk_EX or posedge rst_EX) begin
        if (rst_EX) begin
            cnt        <= '0;
            op_q       <= MDU_MUL;
            neg_main   <= 1'b0;
            neg_rem    <= 1'b0;
            div0       <= 1'b0;
            dividend_q <= '0;
            b_mag      <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            hi         <= '0;
            lo         <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                cnt        <= '0;
                op_q       <= op;
                neg_main   <= is_signed && (op_a[31] ^ op_b[31]);
                neg_rem    <= is_signed && op_a[31];
                div0       <= (op == MDU_DIV) && (op_b == 32'd0);
                dividend_q <= op_a;
                b_mag      <= abs32(op_b, is_signed);
                acc_hi     <= '0;
                acc_lo     <= abs32(op_a, is_signed);
            end
        end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                hi <= fin_hi;
                lo <= fin_lo;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage -- MIPS execute stage.
// Single-cycle ALU ops are registered one cycle after acceptance; mult/div
// are handed to ex_mdu, which stalls the upstream stage while it iterates.
// Ports:
//   clk_EX, rst_EX      clock, asynchronous active-high reset
//   data1_EX, data2_EX  rs / rt operands
//   funct_EX            sign-extended immediate; [5:0] is the funct code
//   rd_EX, shamt_EX     destination register, shift amount
//   nextIns_EX          next-instruction address, passed through
//   valid_EX            input bundle is a live instruction
//   result_EX, rdOut_EX, wrEn_EX, nextInsOut_EX   registered outputs
//   stall_EX            upstream must hold its bundle
module ex_stage
    import mips_pkg::*;
#(
    parameter int NEXT_W = 8
) (
    input  logic              clk_EX,
    input  logic              rst_EX,
    input  logic [31:0]       data1_EX,
    input  logic [31:0]       data2_EX,
    input  logic [31:0]       funct_EX,
    input  logic [4:0]        rd_EX,
    input  logic [4:0]        shamt_EX,
    input  logic [NEXT_W-1:0] nextIns_EX,
    input  logic              valid_EX,
    output logic [31:0]       result_EX,
    output logic [4:0]        rdOut_EX,
    output logic              wrEn_EX,
    output logic [NEXT_W-1:0] nextInsOut_EX,
    output logic              stall_EX
);

    logic [5:0]  fc;
    logic        unused_funct_hi;
    logic [31:0] alu_res;
    logic        alu_wr;
    logic        is_md, md_signed;
    mdu_op_t     md_op;
    logic        mdu_busy;
    logic [31:0] mdu_hi, mdu_lo;
    logic        accept;

    assign fc              = funct_EX[5:0];
    assign unused_funct_hi = ^funct_EX[31:6];

    always_comb begin
        alu_res   = '0;
        alu_wr    = 1'b1;
        is_md     = 1'b0;
        md_signed = 1'b0;
        md_op     = MDU_MUL;
        case (fc)
            F_SLL:          alu_res = data2_EX << shamt_EX;
            F_SRL:          alu_res = data2_EX >> shamt_EX;
            F_SRA:          alu_res = $signed(data2_EX) >>> shamt_EX;
            F_MFHI:         alu_res = mdu_hi;
            F_MFLO:         alu_res = mdu_lo;
            F_ADD, F_ADDU:  alu_res = data1_EX + data2_EX;
            F_SUB, F_SUBU:  alu_res = data1_EX - data2_EX;
            F_AND:          alu_res = data1_EX & data2_EX;
            F_OR:           alu_res = data1_EX | data2_EX;
            F_XOR:          alu_res = data1_EX ^ data2_EX;
            F_NOR:          alu_res = ~(data1_EX | data2_EX);
            F_SLT:          alu_res = {31'd0, $signed(data1_EX) < $signed(data2_EX)};
            F_SLTU:         alu_res = {31'd0, data1_EX < data2_EX};
            F_MULT:  begin alu_wr = 1'b0; is_md = 1'b1; md_signed = 1'b1; end
            F_MULTU: begin alu_wr = 1'b0; is_md = 1'b1; end
            F_DIV:   begin alu_wr = 1'b0; is_md = 1'b1; md_signed = 1'b1; md_op = MDU_DIV; end
            F_DIVU:  begin alu_wr = 1'b0; is_md = 1'b1; md_op = MDU_DIV; end
            default:        alu_wr = 1'b0;
        endcase
    end

    assign accept   = valid_EX && !mdu_busy;
    assign stall_EX = mdu_busy;

    ex_mdu u_mdu (
        .clk_EX    (clk_EX),
        .rst_EX    (rst_EX),
        .start     (accept && is_md),
        .is_signed (md_signed),
        .op        (md_op),
        .op_a      (data1_EX),
        .op_b      (data2_EX),
        .busy      (mdu_busy),
        .hi        (mdu_hi),
        .lo        (mdu_lo)
    );

    // While the MDU is busy the inputs are ignored: outputs hold, no write.
    always_ff @(posedge clk_EX or posedge rst_EX) begin
        if (rst_EX) begin
            result_EX     <= '0;
            rdOut_EX      <= '0;
            wrEn_EX       <= 1'b0;
            nextInsOut_EX <= '0;
        end else if (!mdu_busy) begin
            result_EX     <= alu_res;
            rdOut_EX      <= rd_EX;
            wrEn_EX       <= valid_EX && alu_wr;
            nextInsOut_EX <= nextIns_EX;
        end else begin
            wrEn_EX       <= 1'b0;
        end
    end

endmodule
